// File: rtl/iomem_pkg.sv
// Shared definitions for the I/O memory channel mux: FSM encoding and the
// read data returned when a handshake channel times out.
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/iomem_mux.sv
// Decodes one 64 KiB bus page and fans each access out to one of up to eight
// peripheral channels, each either zero-wait or ready-handshaked with timeout.
module iomem_mux
    import iomem_pkg::*;
#(
    parameter logic [15:0]         ADDR      = 16'h0300,
    parameter int unsigned         CHANNELS  = 4,
    parameter int unsigned         CH_LSB    = 8,
    parameter logic [CHANNELS-1:0] WAIT_MASK = '0,
    parameter int unsigned         TIMEOUT   = 15
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic [3:0]              wstrb,
    input  logic [31:0]             addr,
    output logic                    ready,
    output logic [31:0]             rdata,
    output logic [CHANNELS-1:0]     ch_we,
    output logic [CHANNELS-1:0]     ch_re,
    input  logic [CHANNELS-1:0]     ch_ready,
    input  logic [32*CHANNELS-1:0]  ch_rdata,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ch_q, ch_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          timeout;

    logic [2:0]    ch_field;
    logic          wr;
    logic          hit;
    logic          in_range;
    logic [2:0]    sel;
    logic [31:0]   sel_rdata;
    logic          sel_ready;
    logic          sel_wait;
    logic          addr_unused;

    assign ch_field    = addr[CH_LSB+2 -: 3];
    assign wr          = |wstrb;
    assign hit         = valid && (addr[31:16] == ADDR) && (state_q == IDLE);
    assign in_range    = 32'(ch_field) < CHANNELS;
    assign addr_unused = ^addr;

    // In IDLE the channel comes straight from the address; once waiting it
    // comes from the latched copy so the bus address may change underneath.
    assign sel = (state_q == IDLE) ? ch_field : ch_q;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_wait  = 1'b0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (32'(sel) == n) begin
                sel_rdata = ch_rdata[n*32 +: 32];
                sel_ready = ch_ready[n];
                sel_wait  = WAIT_MASK[n];
            end
        end
    end

    always_comb begin
        ch_we = '0;
        ch_re = '0;
        if (rst_n && hit && in_range) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (32'(ch_field) == n) begin
                    ch_we[n] = wr;
                    ch_re[n] = !wr;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        wr_d    = wr_q;
        rdata_d = '0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (in_range && sel_wait) begin
                        ch_d    = ch_field;
                        wr_d    = wr;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end else begin
                        rdata_d = (in_range && !wr) ? sel_rdata : '0;
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (sel_ready) begin
                    rdata_d = wr_q ? '0 : sel_rdata;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    rdata_d = TIMEOUT_DATA;
                    timeout = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_n suppresses the pulse if reset lands on the DONE cycle.
    assign ready = rst_n && (state_q == DONE);
    assign rdata = ready ? rdata_q : '0;
    assign err   = err_q;

endmodule

// File: tb/tb_iomem_mux.sv
// Self-checking bench for iomem_mux: directed vector table, abort sequences,
// and randomized accesses checked against a transaction-level model.
module tb_iomem_mux;

    localparam int          TMO   = 15;
    localparam logic [3:0]  WMASK = 4'b0100;
    localparam logic [127:0] TDATA = {32'hA5A55A5A, 32'h0BADC0DE, 32'h12345678, 32'hCAFEF00D};

    logic          ck = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [3:0]    wstrb;
    logic [31:0]   addr;
    logic          ready;
    logic [31:0]   rdata;
    logic [3:0]    ch_we;
    logic [3:0]    ch_re;
    logic [3:0]    ch_ready;
    logic [127:0]  ch_rdata;
    logic          err;
    logic          err_clr;

    int total = 0;
    int passed = 0;

    iomem_mux #(
        .ADDR(16'h0300),
        .CHANNELS(4),
        .CH_LSB(8),
        .WAIT_MASK(WMASK),
        .TIMEOUT(TMO)
    ) dut (
        .ck(ck),
        .rst_n(rst_n),
        .valid(valid),
        .wstrb(wstrb),
        .addr(addr),
        .ready(ready),
        .rdata(rdata),
        .ch_we(ch_we),
        .ch_re(ch_re),
        .ch_ready(ch_ready),
        .ch_rdata(ch_rdata),
        .err(err),
        .err_clr(err_clr)
    );

    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // One bus access; exp_lat = 0 means no ready is expected within 20 cycles.
    task automatic do_access(input int id, input logic [15:0] page, input int c, input bit wr,
                             input int k, input bit clr, input int clr_at, input logic [127:0] data,
                             input logic [3:0] exp_we, input logic [3:0] exp_re, input int exp_lat,
                             input logic [31:0] exp_rd, input bit exp_er);
        int          lat;
        int          limit;
        bit          extra;
        logic [31:0] rd_obs;
        logic        err_obs;
        logic [15:0] low;
        logic [3:0]  noise;
        @(negedge ck);
        err_clr  = clr;
        valid    = 1'b0;
        ch_ready = '0;
        ch_rdata = data;
        @(negedge ck);
        err_clr  = 1'b0;
        low      = 16'($urandom);
        low[10:8] = 3'(c);
        addr     = {page, low};
        wstrb    = wr ? 4'($urandom_range(1, 15)) : 4'h0;
        noise    = 4'($urandom) & 4'b1011;
        ch_ready = noise;
        valid    = 1'b1;
        #1;
        chk($sformatf("acc%0d_strobe", id), {56'h0, ch_we, ch_re}, {56'h0, exp_we, exp_re});
        limit  = (exp_lat == 0) ? 20 : 40;
        lat    = 0;
        extra  = 1'b0;
        rd_obs = '0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge ck);
            if (ready) begin
                lat    = i;
                rd_obs = rdata;
                break;
            end
            if (ch_we != 4'h0 || ch_re != 4'h0 || rdata != 32'h0) extra = 1'b1;
            ch_ready = noise | ((i == k && c < 4) ? 4'(1 << c) : 4'h0);
            err_clr  = (i == clr_at);
        end
        err_obs  = err;
        valid    = 1'b0;
        err_clr  = 1'b0;
        ch_ready = '0;
        chk($sformatf("acc%0d_latency", id), 64'(lat), 64'(exp_lat));
        chk($sformatf("acc%0d_rdata", id), {32'h0, rd_obs}, {32'h0, exp_rd});
        chk($sformatf("acc%0d_err", id), {63'h0, err_obs}, {63'h0, exp_er});
        chk($sformatf("acc%0d_quiet_between", id), {63'h0, extra}, 64'h0);
    endtask

    // Handshake read on channel 2 abandoned in WAIT cycle 2 by valid drop or reset.
    task automatic do_abort(input bit use_rst);
        bit saw;
        string tag;
        tag = use_rst ? "rst_abort" : "valid_drop";
        @(negedge ck);
        err_clr  = 1'b0;
        ch_ready = '0;
        ch_rdata = TDATA;
        addr     = {16'h0300, 5'h0, 3'd2, 8'h40};
        wstrb    = 4'h0;
        valid    = 1'b1;
        @(negedge ck);
        saw = ready;
        @(negedge ck);
        saw = saw | ready;
        if (use_rst) rst_n = 1'b0;
        else         valid = 1'b0;
        #1;
        chk({tag, "_strobe"}, {56'h0, ch_we, ch_re}, 64'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            rst_n = 1'b1;
            valid = 1'b0;
            if (ready) saw = 1'b1;
        end
        chk({tag, "_no_ready"}, {63'h0, saw}, 64'h0);
        chk({tag, "_err"}, {63'h0, err}, 64'h0);
    endtask

    typedef struct {
        logic [15:0] page;
        int          c;
        bit          wr;
        int          k;
        bit          clr;
        int          clr_at;
        logic [3:0]  we;
        logic [3:0]  re;
        int          lat;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit          err_m;
        logic [15:0] page;
        int          c, k, lat;
        bit          wr, clr;
        logic [127:0] data;
        logic [3:0]  ewe, ere;
        logic [31:0] erd;

        tbl[0]  = '{16'h0300, 1, 1'b0, 1,  1'b0, -1, 4'h0, 4'h2, 1,  32'h12345678, 1'b0};
        tbl[1]  = '{16'h0300, 1, 1'b1, 1,  1'b0, -1, 4'h2, 4'h0, 1,  32'h00000000, 1'b0};
        tbl[2]  = '{16'h0300, 0, 1'b0, 1,  1'b0, -1, 4'h0, 4'h1, 1,  32'hCAFEF00D, 1'b0};
        tbl[3]  = '{16'h0300, 3, 1'b1, 1,  1'b0, -1, 4'h8, 4'h0, 1,  32'h00000000, 1'b0};
        tbl[4]  = '{16'h0300, 3, 1'b0, 1,  1'b0, -1, 4'h0, 4'h8, 1,  32'hA5A55A5A, 1'b0};
        tbl[5]  = '{16'h0300, 2, 1'b1, 3,  1'b0, -1, 4'h4, 4'h0, 4,  32'h00000000, 1'b0};
        tbl[6]  = '{16'h0300, 2, 1'b0, 1,  1'b0, -1, 4'h0, 4'h4, 2,  32'h0BADC0DE, 1'b0};
        tbl[7]  = '{16'h0300, 2, 1'b0, 16, 1'b0, -1, 4'h0, 4'h4, 17, 32'h0BADC0DE, 1'b0};
        tbl[8]  = '{16'h0301, 1, 1'b0, 1,  1'b0, -1, 4'h0, 4'h0, 0,  32'h00000000, 1'b0};
        tbl[9]  = '{16'h0300, 5, 1'b0, 1,  1'b0, -1, 4'h0, 4'h0, 1,  32'h00000000, 1'b0};
        tbl[10] = '{16'h0300, 7, 1'b1, 1,  1'b0, -1, 4'h0, 4'h0, 1,  32'h00000000, 1'b0};
        tbl[11] = '{16'h0300, 2, 1'b0, 99, 1'b0, -1, 4'h0, 4'h4, 17, 32'hDEADBEEF, 1'b1};
        tbl[12] = '{16'h0300, 1, 1'b0, 1,  1'b0, -1, 4'h0, 4'h2, 1,  32'h12345678, 1'b1};
        tbl[13] = '{16'h0300, 0, 1'b1, 1,  1'b1, -1, 4'h1, 4'h0, 1,  32'h00000000, 1'b0};
        tbl[14] = '{16'h0300, 2, 1'b1, 99, 1'b0, 16, 4'h4, 4'h0, 17, 32'hDEADBEEF, 1'b1};
        tbl[15] = '{16'h0300, 3, 1'b0, 1,  1'b1, -1, 4'h0, 4'h8, 1,  32'hA5A55A5A, 1'b0};

        rst_n    = 1'b0;
        valid    = 1'b0;
        wstrb    = 4'h0;
        addr     = '0;
        ch_ready = '0;
        ch_rdata = TDATA;
        err_clr  = 1'b0;
        repeat (3) @(negedge ck);
        chk("reset_ready", {63'h0, ready}, 64'h0);
        chk("reset_rdata", {32'h0, rdata}, 64'h0);
        chk("reset_err", {63'h0, err}, 64'h0);
        chk("reset_strobe", {56'h0, ch_we, ch_re}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            do_access(i, tbl[i].page, tbl[i].c, tbl[i].wr, tbl[i].k, tbl[i].clr, tbl[i].clr_at,
                      TDATA, tbl[i].we, tbl[i].re, tbl[i].lat, tbl[i].rd, tbl[i].er);

        do_abort(1'b0);
        do_access(50, 16'h0300, 1, 1'b0, 1, 1'b0, -1, TDATA, 4'h0, 4'h2, 1, 32'h12345678, 1'b0);
        do_access(51, 16'h0300, 2, 1'b0, 99, 1'b0, -1, TDATA, 4'h0, 4'h4, 17, 32'hDEADBEEF, 1'b1);
        do_abort(1'b1);
        do_access(52, 16'h0300, 2, 1'b0, 2, 1'b0, -1, TDATA, 4'h0, 4'h4, 3, 32'h0BADC0DE, 1'b0);

        err_m = 1'b0;
        for (int n = 0; n < 200; n++) begin
            page = ($urandom_range(0, 7) == 0) ? (16'h0300 ^ 16'($urandom_range(1, 65535))) : 16'h0300;
            c    = $urandom_range(0, 7);
            wr   = 1'($urandom);
            k    = $urandom_range(1, 20);
            clr  = ($urandom_range(0, 3) == 0);
            data = {$urandom, $urandom, $urandom, $urandom};

            if (clr) err_m = 1'b0;
            ewe = 4'h0;
            ere = 4'h0;
            lat = 0;
            erd = 32'h0;
            if (page == 16'h0300) begin
                if (c < 4) begin
                    if (wr) ewe = 4'(1 << c);
                    else    ere = 4'(1 << c);
                end
                if (c >= 4 || !WMASK[c]) begin
                    lat = 1;
                    erd = (c < 4 && !wr) ? data[c*32 +: 32] : 32'h0;
                end else if (k <= TMO + 1) begin
                    lat = k + 1;
                    erd = wr ? 32'h0 : data[c*32 +: 32];
                end else begin
                    lat   = TMO + 2;
                    erd   = 32'hDEADBEEF;
                    err_m = 1'b1;
                end
            end
            do_access(100 + n, page, c, wr, k, clr, -1, data, ewe, ere, lat, erd, err_m);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iomem_mux.md
IOMEM_MUX -- requirements
Module: iomem_mux

Interface
REQ-001 SHALL have parameter ADDR, default 16'h0300, matched against addr[31:16] to select this block.
REQ-002 SHALL have parameter CHANNELS, default 4, range 1..8, number of peripheral channels.
REQ-003 SHALL have parameter CH_LSB, default 8, LSB of 3-bit channel field addr[CH_LSB+2:CH_LSB].
REQ-004 SHALL have parameter WAIT_MASK, default 0, CHANNELS bits wide; bit n=1 means channel n uses the ch_ready handshake, bit n=0 means zero-wait.
REQ-005 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before forced completion.
REQ-006 SHALL have one clock and a synchronous, active-low reset: ck input 1 (clock), rst_n input 1 (sync reset, active low).
REQ-007 SHALL have ports:
- valid input 1: bus request
- wstrb input 4: byte strobes; any bit set means write
- addr input 32: bus address
- ready output 1: one-cycle completion pulse
- rdata output 32: read data, valid while ready is high
- ch_we output CHANNELS: one-hot write strobe
- ch_re output CHANNELS: one-hot read strobe
- ch_ready input CHANNELS: per-channel done
- ch_rdata input 32*CHANNELS: per-channel read data, channel n at bits [32n+31:32n]
- err output 1: sticky timeout flag
- err_clr input 1: clears err

Function
REQ-008 SHALL define hit = valid && addr[31:16]==ADDR && state==IDLE.
REQ-009 SHALL use states IDLE, WAIT, DONE.
REQ-010 SHALL, in IDLE on hit with channel c < CHANNELS, drive ch_we[c] (write) or ch_re[c] (read) combinationally high for exactly that cycle, with all other strobe bits 0.
REQ-011 SHALL, on hit to a zero-wait channel, capture ch_rdata[c] (reads) or 0 (writes) into rdata, go to DONE, and assert ready on the next cycle (latency 1).
REQ-012 SHALL, on hit to a handshake channel, latch c and the direction, clear the counter, and go to WAIT.
REQ-013 SHALL, in WAIT when ch_ready[c]=1, capture ch_rdata[c] (reads) or 0 (writes) and go to DONE.
REQ-014 SHALL, in WAIT when ch_ready[c]=0, increment the counter; when the counter equals TIMEOUT, load rdata=32'hDEADBEEF, set err, and go to DONE.
REQ-015 SHALL complete an access with ready only after exactly 1 + the number of WAIT cycles, with ready no later than TIMEOUT+2 cycles after the hit.
REQ-016 SHALL, in DONE, hold ready=1 for exactly one cycle and then return to IDLE; no strobe and no hit occurs while ready=1.
REQ-017 SHALL, on hit with channel >= CHANNELS, assert no strobe, complete via DONE with rdata=0 and latency 1, and leave err unchanged.
REQ-018 SHALL, on an address page mismatch, give no strobe, no ready, and no state change.
REQ-019 SHALL, if valid falls while in WAIT, return to IDLE without asserting ready or setting err.
REQ-020 SHALL drive rdata=0 whenever ready=0.
REQ-021 SHALL clear err on err_clr; if err_clr and a timeout occur in the same cycle, set wins.
REQ-022 SHALL size the counter as clog2(TIMEOUT+1) bits, with no wrap-around before TIMEOUT is reached.

Reset
REQ-023 SHALL, when rst_n=0 at a ck edge, set state=IDLE, ready=0, rdata=0, err=0, counter=0, with ch_we and ch_re 0 on the following cycle.
REQ-024 SHALL, on reset during WAIT or DONE, abort the access with no ready pulse.

Structure
REQ-025 SHALL place the state encoding and the TIMEOUT_DATA=32'hDEADBEEF constant in shared package iomem_pkg.
REQ-026 SHALL be a single module with no sub-modules; the counter and the channel mux are inline.

Verification
REQ-027 SHALL cover: zero-wait read ch1, ADDR match, ch_rdata[1]=32'h12345678 -> ch_re=4'b0010 for 1 cycle, ready at +1 with rdata=32'h12345678.
REQ-028 SHALL cover: WAIT_MASK=4'b0100, write ch2, ch_ready[2] raised after 3 cycles -> ch_we=4'b0100 for 1 cycle, ready at +4, rdata=0, err=0.
REQ-029 SHALL cover: handshake read with ch_ready held low -> ready at +TIMEOUT+2 (17 for the default), rdata=32'hDEADBEEF, err=1 until err_clr.
REQ-030 SHALL cover: addr[31:16]=16'h0301 -> no strobe and no ready for 20 cycles; channel field=5 with CHANNELS=4 -> ready at +1, rdata=0.
REQ-031 SHALL cover: valid dropped in cycle 2 of WAIT -> IDLE, no ready, err=0; next valid hit accepted normally.
REQ-032 SHALL cover: rst_n=0 during WAIT -> ready never pulses, err=0, next access completes normally.
